word_score_sequencer: RTL
=========================

// Module: word_score_sequencer
// PURPOSE
//   Runs one word-guess game round by round against a latched target word.
//   For each accepted guess it derives FullMatch, FirstHalf, SecondHalf and a bonus Flag.
//   It scores the guess with the team's point rule (10/8/5/2) and accumulates a saturating total.
//   Sits between the guess source (valid/ready) and the score display/readout logic.
// PARAMETERS
//   WORD_W   16  guess/target width; must be even; halves = [WORD_W-1:WORD_W/2], [WORD_W/2-1:0]
//   ROUNDS   8   guesses per game, >=1
//   SCORE_W  16  accumulator width
// PORTS
//   Clk         in   1                  clock, rising edge
//   Reset       in   1                  asynchronous, active-high
//   Start       in   1                  begin game; sampled only in IDLE or DONE
//   TargetIn    in   WORD_W             target word, latched on accepted Start
//   GuessValid  in   1                  guess handshake valid
//   GuessWord   in   WORD_W             guess data
//   GuessReady  out  1                  high only in WAIT
//   Points      out  16                 points of last scored guess (10/8/5/2)
//   PointsValid out  1                  1-cycle pulse when Points/Score update
//   Score       out  SCORE_W            running total, saturating
//   Round       out  $clog2(ROUNDS+1)   guesses scored this game
//   Busy        out  1                  high in WAIT/EVAL/ACCUM
//   Done        out  1                  high in DONE
// BEHAVIOUR
//   - Reset (async): state=IDLE; Points=0, PointsValid=0, Score=0, Round=0, Busy=0, Done=0, GuessReady=0.
//   - Reset also clears the Flag register and the target register.
//   - IDLE: Start=1 -> latch TargetIn; clear Score, Round, Flag -> WAIT.
//   - WAIT: GuessReady=1; GuessValid&GuessReady at edge k -> capture guess -> EVAL.
//   - EVAL (1 cycle): register match bits from the captured guess:
//       FullMatch  = guess == target
//       FirstHalf  = upper halves equal
//       SecondHalf = lower halves equal
//     The point priority, from highest to lowest, is:
//       SecondHalf&Flag -> 10
//       FullMatch -> 8
//       FirstHalf -> 5
//       else -> 2
//   - ACCUM (1 cycle), at its exit edge:
//       Score += Points, saturating at 2^SCORE_W-1
//       Round += 1; Points updated; PointsValid pulses 1 cycle
//       Flag <= FirstHalf of this guess (bonus carries to next guess only)
//     Next state: Round==ROUNDS -> DONE, else WAIT.
//   - Latency: guess accepted at edge k -> Score/Points/PointsValid visible after edge k+2.
//     The next GuessReady=1 also follows edge k+2.
//   - DONE: Done=1; Score/Round held; Start=1 restarts as in IDLE (TargetIn re-latched).
//   - Start ignored while Busy. GuessValid ignored outside WAIT (no capture, no stall state).
//   - Guess words are not buffered: the source holds data until GuessReady.
//   - Reset mid-game (any state) aborts immediately to reset values; no partial score survives.
//   - Round never exceeds ROUNDS; Score never wraps.
// CONFIGURATION
//   WORD_SCORE_EARLY_EXIT_EN defined:
//     A guess with FullMatch=1 ends the game after its ACCUM (-> DONE) even if Round<ROUNDS.
//   Not defined:
//     Game always runs exactly ROUNDS guesses; FullMatch only affects points.
// TESTING
//   1. Assert Reset mid-stream -> all outputs 0, GuessReady=0, state IDLE, Done=0.
//   2. Target 16'hABCD; guesses 16'hAB00, 16'h12CD, 16'hABCD:
//      -> Points 5, 10 (Flag from prior FirstHalf), 8; Score=23, Round=3.
//   3. ROUNDS=8, eight guesses 16'h0000 vs 16'hABCD -> each Points=2; Score=16.
//      Done=1 after 8th ACCUM; further GuessValid ignored.
//   4. SCORE_W=4, eight guesses 16'hABCD -> Score 8 then 15 and held at 15 (saturate); no wrap.
//   5. Accept a guess, then assert Reset during EVAL -> Score=0, Round=0, no PointsValid.
//      A new Start then runs a full game correctly.
//   6. With WORD_SCORE_EARLY_EXIT_EN, first guess 16'hABCD -> Done after 1 round, Score=8, Round=1.
//      Without the macro -> WAIT, GuessReady=1.

Source files
------------

// File: rtl/word_score_sequencer.sv
// ----------------------------------------------------------------------------
// word_score_sequencer
//   Plays one word-guess game against a target word latched at Start.
//   Each guess accepted over the valid/ready handshake is compared against the
//   target (full word, upper half, lower half). It is scored 10/8/5/2 and added
//   to a saturating running total. A bonus flag carries the "upper half
//   matched" result from one guess to the next guess only.
//
//   Pipeline: WAIT (accept) -> EVAL (register match bits) -> ACCUM (score).
//   A guess accepted at edge k produces Points/Score/PointsValid after
//   edge k+2.
//
// Optional feature (compile-time macro WORD_SCORE_EARLY_EXIT_EN):
//   When this macro is defined, a full-word match ends the game after its
//   ACCUM, even if fewer than ROUNDS guesses have been made.
//   When it is undefined, every game runs exactly ROUNDS guesses.
//
// Parameters
//   WORD_W   guess/target width (even)
//   ROUNDS   guesses per game (>=1)
//   SCORE_W  accumulator width
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         asynchronous active-high reset
//   i_start         begin a game (honoured only in IDLE or DONE)
//   i_target_in     target word, latched on an accepted start
//   i_guess_valid   guess handshake valid
//   i_guess_word    guess data
//   o_guess_ready   high only in WAIT
//   o_points        points of the last scored guess
//   o_points_valid  one-cycle pulse when o_points/o_score update
//   o_score         saturating running total
//   o_round         number of guesses scored in this game
//   o_busy          high in WAIT/EVAL/ACCUM
//   o_done          high in DONE
// ----------------------------------------------------------------------------
module word_score_sequencer #(
   parameter int WORD_W  = 16,
   parameter int ROUNDS  = 8,
   parameter int SCORE_W = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_start,
   input  logic [WORD_W-1:0]            i_target_in,
   input  logic                         i_guess_valid,
   input  logic [WORD_W-1:0]            i_guess_word,
   output logic                         o_guess_ready,
   output logic [15:0]                  o_points,
   output logic                         o_points_valid,
   output logic [SCORE_W-1:0]           o_score,
   output logic [$clog2(ROUNDS+1)-1:0]  o_round,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam int HALF_W  = WORD_W / 2;
   localparam int ROUND_W = $clog2(ROUNDS + 1);
   // One bit wider than the wider operand, so the raw sum can never wrap
   // before the saturation check.
   localparam int SUM_W   = ((SCORE_W > 16) ? SCORE_W : 16) + 1;
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_EVAL  = 3'd2,
      S_ACCUM = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Point rule. The lower-half-with-bonus case outranks a full match.
   function automatic logic [15:0] f_points(input logic full_m, input logic first_m,
                                            input logic second_m, input logic flag);
      logic [15:0] pts;
      if (second_m && flag) begin
         pts = 16'd10;
      end else if (full_m) begin
         pts = 16'd8;
      end else if (first_m) begin
         pts = 16'd5;
      end else begin
         pts = 16'd2;
      end
      return pts;
   endfunction

   // Saturating accumulate: the result is clamped at all-ones and never wraps.
   function automatic logic [SCORE_W-1:0] f_sat_add(input logic [SCORE_W-1:0] acc,
                                                    input logic [15:0] pts);
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] max_val;
      sum     = SUM_W'(acc) + SUM_W'(pts);
      max_val = SUM_W'({SCORE_W{1'b1}});
      if (sum > max_val) begin
         return {SCORE_W{1'b1}};
      end else begin
         return sum[SCORE_W-1:0];
      end
   endfunction

   state_t               r_state;
   state_t               w_next_state;
   logic [WORD_W-1:0]    r_target;
   logic [WORD_W-1:0]    r_guess;
   logic                 r_full;
   logic                 r_first;
   logic                 r_second;
   logic                 r_flag;
   logic [15:0]          r_points;
   logic                 r_points_valid;
   logic [SCORE_W-1:0]   r_score;
   logic [ROUND_W-1:0]   r_round;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_start_game;
   logic                 w_accept;
   logic                 w_last;
   logic [ROUND_W-1:0]   w_round_inc;
   logic [15:0]          w_points;
   logic [SCORE_W-1:0]   w_score_next;

   assign w_round_inc  = r_round + ROUND_W'(1);
   assign w_points     = f_points(r_full, r_first, r_second, r_flag);
   assign w_score_next = f_sat_add(r_score, w_points);

`ifdef WORD_SCORE_EARLY_EXIT_EN
   assign w_last = (w_round_inc == ROUND_LAST) || r_full;
`else
   assign w_last = (w_round_inc == ROUND_LAST);
`endif

   // Next-state decode plus the start/accept strobes used by the datapath.
   always_comb begin
      w_next_state = r_state;
      w_start_game = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next_state = S_WAIT;
               w_start_game = 1'b1;
            end else begin
               w_next_state = r_state;
            end
         end
         S_WAIT: begin
            if (i_guess_valid) begin
               w_next_state = S_EVAL;
               w_accept     = 1'b1;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_EVAL: begin
            w_next_state = S_ACCUM;
         end
         S_ACCUM: begin
            if (w_last) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: target/guess capture, match bits, scoring, and the status flags
   // registered from the next state so they line up with the state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_target       <= {WORD_W{1'b0}};
         r_guess        <= {WORD_W{1'b0}};
         r_full         <= 1'b0;
         r_first        <= 1'b0;
         r_second       <= 1'b0;
         r_flag         <= 1'b0;
         r_points       <= 16'd0;
         r_points_valid <= 1'b0;
         r_score        <= {SCORE_W{1'b0}};
         r_round        <= {ROUND_W{1'b0}};
         r_ready        <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         if (w_start_game) begin
            r_target <= i_target_in;
            r_score  <= {SCORE_W{1'b0}};
            r_round  <= {ROUND_W{1'b0}};
            r_flag   <= 1'b0;
         end
         if (w_accept) begin
            r_guess <= i_guess_word;
         end
         if (r_state == S_EVAL) begin
            r_full   <= (r_guess == r_target);
            r_first  <= (r_guess[WORD_W-1:HALF_W] == r_target[WORD_W-1:HALF_W]);
            r_second <= (r_guess[HALF_W-1:0] == r_target[HALF_W-1:0]);
         end
         if (r_state == S_ACCUM) begin
            r_points <= w_points;
            r_score  <= w_score_next;
            r_round  <= w_round_inc;
            // The bonus applies to the next guess only, so it is overwritten
            // on every guess.
            r_flag   <= r_first;
         end
         r_points_valid <= (r_state == S_ACCUM);
         r_ready        <= (w_next_state == S_WAIT);
         r_busy         <= (w_next_state == S_WAIT) || (w_next_state == S_EVAL) ||
                           (w_next_state == S_ACCUM);
         r_done         <= (w_next_state == S_DONE);
      end
   end

   assign o_guess_ready  = r_ready;
   assign o_points       = r_points;
   assign o_points_valid = r_points_valid;
   assign o_score        = r_score;
   assign o_round        = r_round;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule
